// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory write path: loader state
// encoding and instruction word geometry.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_W        = 32;

endpackage

// File: rtl/imem_loader.sv
// Packs a big-endian byte stream into instruction words and writes them from address 0 up.
// Latency: mem_we rises one cycle after the 4th byte of a word is accepted.
// Backpressure: in_ready is high only while collecting bytes; the write cycle stalls the source.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]      LAST_IX = 2'(BYTES_PER_WORD - 1);

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   word_q;
    logic [DATA_W-1:0]   word_shift;
    logic [1:0]          byte_idx;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     remaining;
    logic                count_ok;
    logic                start_ok;
    logic                start_bad;
    logic                xfer;
    logic                last_byte;

    assign count_ok   = (word_count != '0) && (word_count <= DEPTH_W);
    assign start_ok   = (state == ST_IDLE) && start && count_ok;
    assign start_bad  = (state == ST_IDLE) && start && !count_ok;
    assign in_ready   = (state == ST_RECV);
    // Abort wins over a simultaneous byte, so that byte never enters the word.
    assign xfer       = in_ready && in_valid && !abort;
    assign last_byte  = xfer && (byte_idx == LAST_IX);
    assign word_shift = {word_q[DATA_W-9:0], in_byte};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_RECV;
            ST_RECV: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (last_byte) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (abort)                                state_nxt = ST_IDLE;
                else if (remaining == (ADDR_W + 1)'(1))   state_nxt = ST_DONE;
                else                                      state_nxt = ST_RECV;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word_q    <= '0;
            byte_idx  <= '0;
            addr      <= '0;
            remaining <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != ST_IDLE);
            cpu_hold <= (state_nxt != ST_IDLE);
            mem_we   <= (state_nxt == ST_WRITE);
            done     <= (state_nxt == ST_DONE);
            err      <= start_bad;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        remaining <= word_count;
                        addr      <= '0;
                        byte_idx  <= '0;
                        word_q    <= '0;
                    end
                end
                ST_RECV: begin
                    if (abort) begin
                        byte_idx <= '0;
                    end else if (xfer) begin
                        word_q   <= word_shift;
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            mem_addr  <= addr;
                            mem_wdata <= word_shift;
                        end
                    end
                end
                ST_WRITE: begin
                    // The last increment may wrap addr to 0; DONE follows, so it is never used.
                    if (!abort) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - (ADDR_W + 1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed vectors, corner sequences and randomized loads.
module tb_imem_loader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_byte = '0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t wr_q[$];
    int  done_cnt = 0;
    int  err_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Passive monitor: logs every write and pulse, and checks write-cycle invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wr_q.push_back({mem_addr, mem_wdata});
                check("in_ready_in_write", 32'(in_ready), 32'd0);
                check("hold_in_write", 32'(cpu_hold), 32'd1);
            end
            if (done) done_cnt++;
            if (err)  err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int wc);
        start      = 1'b1;
        word_count = (ADDR_W + 1)'(wc);
        tick();
        start      = 1'b0;
    endtask

    // gap: 0 = valid always, 1 = toggle 1/0, 2 = random. abort_at >= 0 aborts once that many bytes went in.
    task automatic send_bytes(input logic [7:0] b[$], input int gap, input int abort_at,
                              output int accepted);
        int idx = 0;
        int cyc = 0;
        bit tog = 1'b1;
        bit v;
        accepted = -1;
        while (idx < b.size() && cyc < 2000 && accepted < 0) begin
            if (abort_at >= 0 && idx == abort_at && in_ready) begin
                abort    = 1'b1;
                in_valid = 1'b1;
                in_byte  = 8'hEE;
                tick();
                abort    = 1'b0;
                accepted = idx;
            end else begin
                case (gap)
                    0:       v = 1'b1;
                    1:       begin v = tog; tog = ~tog; end
                    default: v = 1'($urandom_range(0, 1));
                endcase
                in_valid = v;
                in_byte  = b[idx];
                v        = v && in_ready;
                tick();
                if (v) idx++;
                cyc++;
            end
        end
        in_valid = 1'b0;
        if (accepted < 0) accepted = idx;
    endtask

    task automatic compare_writes(input string tag, input logic [7:0] b[$], input int exp_words);
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_words));
        for (int i = 0; i < exp_words && i < wr_q.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_q[i].addr), 32'(i));
            check({tag, "_data"}, wr_q[i].data, {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]});
        end
    endtask

    task automatic do_load(input string tag, input int wc, input int gap, input int abort_at,
                           input bit abort_in_done);
        logic [7:0] b[$];
        int acc;
        int cyc;
        int exp_words;
        for (int i = 0; i < wc * 4; i++) b.push_back(8'($urandom));
        wr_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        pulse_start(wc);
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_hold_after_start"}, 32'(cpu_hold), 32'd1);
        send_bytes(b, gap, abort_at, acc);
        if (abort_at >= 0) begin
            exp_words = abort_at / 4;
            check({tag, "_abort_accepted"}, 32'(acc), 32'(abort_at));
            check({tag, "_idle_after_abort"}, 32'({busy, cpu_hold, in_ready}), 32'd0);
            repeat (3) tick();
            check({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
        end else begin
            exp_words = wc;
            check({tag, "_bytes_sent"}, 32'(acc), 32'(wc * 4));
            cyc = 0;
            while (!done && cyc < 20) begin
                tick();
                cyc++;
            end
            check({tag, "_done_seen"}, 32'(done), 32'd1);
            check({tag, "_hold_in_done"}, 32'({busy, cpu_hold}), 32'd3);
            if (abort_in_done) abort = 1'b1;
            tick();
            abort = 1'b0;
            check({tag, "_idle_after_done"}, 32'({busy, cpu_hold, in_ready}), 32'd0);
            check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        end
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        compare_writes(tag, b, exp_words);
    endtask

    // Single-word loads with literal bytes and the big-endian word they must form.
    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_word;
    } word_vec_t;

    // Start requests: rejected ones expect an err pulse, accepted ones run a full load.
    typedef struct {
        int wc;
        bit exp_err;
        int gap;
        int abort_at;
    } start_vec_t;

    initial begin
        word_vec_t  wv[4];
        start_vec_t sv[8];
        logic [7:0] bq[$];
        logic [7:0] bytes4[4];
        int acc;
        int cyc;

        wv[0] = '{8'h00, 8'h01, 8'h10, 8'h20, 32'h0001_1020};
        wv[1] = '{8'h8C, 8'h01, 8'h00, 8'h05, 32'h8C01_0005};
        wv[2] = '{8'hFF, 8'h00, 8'h00, 8'h01, 32'hFF00_0001};
        wv[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h1234_5678};

        sv[0] = '{0,  1'b1, 0, -1};
        sv[1] = '{33, 1'b1, 0, -1};
        sv[2] = '{63, 1'b1, 0, -1};
        sv[3] = '{2,  1'b0, 1, -1};
        sv[4] = '{3,  1'b0, 0, 6};
        sv[5] = '{2,  1'b0, 0, 3};
        sv[6] = '{32, 1'b0, 0, -1};
        sv[7] = '{5,  1'b0, 2, -1};

        #3;
        check("reset_outputs", 32'({in_ready, mem_we, mem_addr, mem_wdata != 0, busy, cpu_hold, done, err}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            bytes4[0] = wv[i].b0; bytes4[1] = wv[i].b1;
            bytes4[2] = wv[i].b2; bytes4[3] = wv[i].b3;
            wr_q.delete();
            pulse_start(1);
            for (int k = 0; k < 4; k++) begin
                check("vec_busy_recv", 32'({busy, cpu_hold, in_ready}), 32'd7);
                in_valid = 1'b1;
                in_byte  = bytes4[k];
                tick();
            end
            in_valid = 1'b0;
            check("vec_we", 32'({mem_we, in_ready, busy}), 32'b101);
            check("vec_addr", 32'(mem_addr), 32'd0);
            check("vec_wdata", mem_wdata, wv[i].exp_word);
            tick();
            check("vec_done", 32'({done, mem_we, busy, cpu_hold}), 32'b1011);
            tick();
            check("vec_idle", 32'({done, busy, cpu_hold}), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            if (sv[i].exp_err) begin
                err_cnt = 0;
                pulse_start(sv[i].wc);
                check("reject_err", 32'(err), 32'd1);
                check("reject_idle", 32'({busy, cpu_hold, in_ready}), 32'd0);
                tick();
                check("reject_err_one_cycle", 32'(err), 32'd0);
                check("reject_err_cnt", 32'(err_cnt), 32'd1);
            end else begin
                do_load($sformatf("tbl%0d", i), sv[i].wc, sv[i].gap, sv[i].abort_at, 1'b0);
            end
        end

        // A second start while receiving must neither restart nor raise err.
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        wr_q.delete(); done_cnt = 0; err_cnt = 0;
        pulse_start(1);
        send_bytes(bq[0:1], 0, -1, acc);
        pulse_start(3);
        check("restart_no_err", 32'(err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        send_bytes(bq[2:3], 0, -1, acc);
        cyc = 0;
        while (!done && cyc < 20) begin tick(); cyc++; end
        check("restart_done", 32'(done), 32'd1);
        tick();
        check("restart_err_cnt", 32'(err_cnt), 32'd0);
        compare_writes("restart", bq, 1);

        // Abort during the DONE cycle is ignored.
        do_load("abort_in_done", 2, 0, -1, 1'b1);

        // Asynchronous reset in the middle of a word.
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        pulse_start(1);
        send_bytes(bq, 0, 2, acc);
        pulse_start(1);
        send_bytes(bq[0:1], 0, -1, acc);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({in_ready, mem_we, mem_addr, mem_wdata != 0, busy, cpu_hold, done, err}), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        do_load("after_reset", 1, 0, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int wc;
            int ab;
            wc = $urandom_range(1, 8);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, wc * 4 - 1) : -1;
            do_load($sformatf("rnd%0d", r), wc, 2, ab, 1'b0);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
